// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t : FSM encoding (IDLE -> SHIFT -> DONE -> IDLE)
//   cnt_w   : bit-counter width for a W-bit operand
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // A 1-bit counter is still needed when W is 2.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
// Ports: x (minuend bit), y (subtrahend bit), bi (borrow in),
//        d (difference bit), bo (borrow out). Purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b - bin (mod 2^W), LSB first,
// one bit per clock through a single full_subtractor cell and a borrow flop.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (a, b, bin sampled on it)
//   out_valid/out_ready   : result handshake
//   diff, bout            : result and unsigned borrow out
//   ovf                   : signed overflow, only when SERIAL_SUB_OVF_EN is defined
// Latency W cycles from input handshake to out_valid; one op per W+2 cycles.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  a_sr, b_sr, res;
  logic [CW-1:0] count;
  logic          br;
  logic          d_bit, bo_bit;

  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Result bits enter at the MSB and shift right, so after W steps the
  // LSB computed first sits at bit 0. diff is driven straight from this
  // register: it only changes in SHIFT, while out_valid is low.
  assign diff = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      count     <= '0;
      br        <= 1'b0;
      bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            br       <= bin;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= {1'b0, a_sr[W-1:1]};
          b_sr  <= {1'b0, b_sr[W-1:1]};
          res   <= {d_bit, res[W-1:1]};
          br    <= bo_bit;
          count <= count + 1'b1;
          if (count == LAST) begin
            bout      <= bo_bit;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: borrow into the sign bit differs from borrow out.
            ovf       <= br ^ bo_bit;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // No new accept on the output-handshake cycle; in_ready rises after.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (W=8), plus hand-written
// backpressure and mid-op reset sequences. Define SERIAL_SUB_OVF_EN to also
// check the ovf port.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one op at a negedge, scramble the inputs after the handshake,
  // then wait (bounded) for out_valid. Leaves the bench at the negedge
  // where out_valid was first seen; the result is not consumed.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                        input string name);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " in_ready before op"}, 64'(in_ready), 64'd1);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(W));
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " out_valid drop"}, 64'(out_valid), 64'd0);
    chk({name, " in_ready back"},  64'(in_ready),  64'd1);
  endtask

  task automatic check_result(input vec_t v, input string name);
    chk({name, " diff"}, 64'(diff), 64'(v.exp_diff));
    chk({name, " bout"}, 64'(bout), 64'(v.exp_bout));
`ifdef SERIAL_SUB_OVF_EN
    chk({name, " ovf"},  64'(ovf),  64'(v.exp_ovf));
`endif
    chk({name, " in_ready in DONE"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [W-1:0] held;

    //           a      b      bin   diff   bout  ovf
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset diff",      64'(diff),      64'd0);
    chk("reset bout",      64'(bout),      64'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset ovf",       64'(ovf),       64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      launch(vecs[i].a, vecs[i].b, vecs[i].bin, nm);
      check_result(vecs[i], nm);
      consume(nm);
    end

    // Backpressure: result must stay put while out_ready is low.
    v = '{8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b0};
    launch(v.a, v.b, v.bin, "bp");
    check_result(v, "bp");
    held = diff;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp hold out_valid", 64'(out_valid), 64'd1);
      chk("bp hold diff",      64'(diff),      64'(held));
      chk("bp hold bout",      64'(bout),      64'(v.exp_bout));
      chk("bp hold in_ready",  64'(in_ready),  64'd0);
    end
    consume("bp");
    v = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0};
    launch(v.a, v.b, v.bin, "bp2");
    check_result(v, "bp2");
    consume("bp2");

    // Reset in the middle of SHIFT abandons the op.
    a = 8'h77; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst mid out_valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready",  64'(in_ready),  64'd1);
    chk("rst mid diff",      64'(diff),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("rst no stale valid", 64'(out_valid), 64'd0);
        break;
      end
    end
    chk("rst post in_ready", 64'(in_ready), 64'd1);
    chk("rst post diff",     64'(diff),     64'd0);
    v = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0};
    launch(v.a, v.b, v.bin, "after_rst");
    check_result(v, "after_rst");
    consume("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if something wedges beyond every bounded wait.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
